// File: rtl/jk_excitation_driver_if.sv
// jk_excitation_driver_if
//   Request/feedback/status bundle between the JK excitation driver and
//   whatever feeds it targets and watches its results.
//   slave  : driver side   (takes tgt_*, q_fb, clr_err; drives the rest)
//   master : user side     (drives tgt_*, q_fb, clr_err; watches the rest)
//   Signals: tgt_valid/tgt_q/tgt_ready request handshake, q_fb flip-flop
//   feedback, j/k excitation, done/err status, clr_err, op_cnt/err_cnt.
interface jk_excitation_driver_if #(
   parameter int CNT_W = 8
);
   logic             tgt_valid;
   logic             tgt_q;
   logic             tgt_ready;
   logic             q_fb;
   logic             j;
   logic             k;
   logic             done;
   logic             err;
   logic             clr_err;
   logic [CNT_W-1:0] op_cnt;
   logic [CNT_W-1:0] err_cnt;

   modport slave (
      input  tgt_valid, tgt_q, q_fb, clr_err,
      output tgt_ready, j, k, done, err, op_cnt, err_cnt
   );

   modport master (
      output tgt_valid, tgt_q, q_fb, clr_err,
      input  tgt_ready, j, k, done, err, op_cnt, err_cnt
   );
endinterface

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//   Drives a JK flip-flop (clocked by clk) to a requested next state by
//   producing the J/K excitation for exactly one edge, then checks the
//   fed-back Q against the target two cycles after acceptance.
//   Ports:
//     clk     rising-edge clock
//     reset   asynchronous active-high reset
//     bus     jk_excitation_driver_if.slave:
//               tgt_valid/tgt_q in, tgt_ready out (high only in IDLE)
//               q_fb in (flip-flop Q), j/k out (registered)
//               done out (1-cycle pulse), err out (sticky)
//               clr_err in (sync clear of err/err_cnt)
//               op_cnt out (wraps), err_cnt out (saturates)
//   Parameters:
//     CNT_W   counter width
//     DC_VAL  value driven on the "don't care" excitation input (0/1)
module jk_excitation_driver #(
   parameter int CNT_W  = 8,
   parameter int DC_VAL = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   jk_excitation_driver_if.slave       bus
);

   localparam logic DC = (DC_VAL != 0);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

   state_t state, state_nxt;
   logic   tgt_lat;
   logic   j_exc, k_exc;
   logic   accept;
   logic   mismatch;

   // Inverse JK table: with Q=0 only J matters (J = target), with Q=1
   // only K matters (K = ~target); the other input is don't-care.
   assign j_exc = bus.q_fb ? DC : bus.tgt_q;
   assign k_exc = bus.q_fb ? ~bus.tgt_q : DC;

   assign bus.tgt_ready = (state == IDLE);
   assign accept        = (state == IDLE) && bus.tgt_valid;
   assign mismatch      = (state == CHECK) && (bus.q_fb != tgt_lat);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.tgt_valid) state_nxt = DRIVE;
         DRIVE:   state_nxt = CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tgt_lat     <= 1'b0;
         bus.j       <= 1'b0;
         bus.k       <= 1'b0;
         bus.done    <= 1'b0;
         bus.err     <= 1'b0;
         bus.op_cnt  <= '0;
         bus.err_cnt <= '0;
      end else begin
         // Excitation is present for the single DRIVE cycle only; the
         // flip-flop holds (J=K=0) everywhere else.
         bus.j    <= 1'b0;
         bus.k    <= 1'b0;
         bus.done <= 1'b0;
         if (accept) begin
            tgt_lat <= bus.tgt_q;
            bus.j   <= j_exc;
            bus.k   <= k_exc;
         end
         if (state == CHECK) begin
            bus.done   <= 1'b1;
            bus.op_cnt <= bus.op_cnt + CNT_W'(1);
         end
         // A mismatch on the same edge as clr_err still records itself,
         // leaving exactly one error counted.
         if (mismatch && bus.clr_err) begin
            bus.err     <= 1'b1;
            bus.err_cnt <= CNT_W'(1);
         end else if (mismatch) begin
            bus.err <= 1'b1;
            if (bus.err_cnt != {CNT_W{1'b1}})
               bus.err_cnt <= bus.err_cnt + CNT_W'(1);
         end else if (bus.clr_err) begin
            bus.err     <= 1'b0;
            bus.err_cnt <= '0;
         end
      end
   end

endmodule
